shifter_arbiter: RTL and testbench
==================================

Name: shifter_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single shared 16-bit combinational Shifter (modes 00 SLL, 01 SRA, 10 ROR).
- Accepts shift commands over valid/ready, latches operands and drives the Shifter inputs.
- Registers the Shifter result and returns it, tagged with the requester id, over a valid/ready response channel.
- Sits between the ALU shift path (requester 0) and the memory byte-alignment path (requester 1).

Parameters:
- DW, 16, data width; only 16 is supported.
- SW, 4, shift-amount width; equals log2(DW).
- CNT_W, 16, width of the grant counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_in  in  DW  requester 0 operand.
- req0_val  in  SW  requester 0 shift amount.
- req0_mode  in  2  requester 0 mode.
- req1_valid, req1_ready, req1_in, req1_val, req1_mode  same as requester 0, for requester 1.
- sh_in  out  DW  to Shifter Shift_In.
- sh_val  out  SW  to Shifter Shift_Val.
- sh_mode  out  2  to Shifter Mode.
- sh_out  in  DW  from Shifter Shift_Out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  id of the requester being answered.
- rsp_data  out  DW  shift result.
- rsp_err  out  1  command carried illegal mode 2'b11.

Behaviour:
- FSM states IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, sh_in=0, sh_val=0, sh_mode=0, last_grant=1 (requester 0 wins the first tie).
- Grant logic is combinational in IDLE:
  - one valid: that requester is granted.
  - both valid: the requester not equal to last_grant is granted.
  - neither valid: no grant.
- reqN_ready = (state==IDLE) & grantN. It is never high outside IDLE. At most one ready is high per cycle.
- Requesters must not make valid depend on ready. A requester holds valid and its fields stable until ready is seen.
- IDLE, accept (valid&ready): latch in/val/mode into the operand register, which drives sh_*. Set last_grant to the accepted id, latch the id, go to EXEC.
- EXEC (exactly 1 cycle): sh_* are held from the operand register. At the clock edge, rsp_data<=sh_out, rsp_id<=latched id, rsp_err<=(mode==2'b11). Go to RESP.
- Illegal mode 2'b11: rsp_data<=the latched operand unchanged (sh_out is ignored) and rsp_err=1.
- RESP: rsp_valid=1, with rsp_data/rsp_id/rsp_err stable. Hold while rsp_ready=0. On rsp_valid&rsp_ready, go to IDLE with rsp_valid=0 next cycle.
- Timing:
  - Latency from accept edge to rsp_valid high: 2 cycles.
  - Minimum spacing between accepts: 3 cycles. No accept occurs in the cycle a response handshakes.
- sh_* hold their last value in IDLE and RESP, and change only on accept.
- Reset asserted in any state: the in-flight command is discarded with no response, all outputs return to reset values the next cycle, and last_grant=1.
- A requester that drops valid before being granted (protocol violation) is simply not served. No state is corrupted.

Optional Feature:
- Macro SHIFT_ARB_CNT_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (out, CNT_W each).
  - Reset to 0.
  - Incremented on each accept of the respective requester.
  - Saturate at all-ones and never wrap.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- req0 SLL: in=0x0001, val=4, mode=00, rsp_ready=1 -> ready0 in the accept cycle, rsp_valid 2 cycles later, rsp_data=0x0010, rsp_id=0, rsp_err=0.
- req1 SRA then ROR:
  - SRA in=0x8000, val=15 -> rsp_data=0xFFFF, rsp_id=1.
  - ROR in=0x0001, val=1 -> rsp_data=0x8000.
- Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0, one accept every 3 cycles. With SHIFT_ARB_CNT_EN, both counters read 2 after 4 responses.
- Illegal mode 11, in=0x1234 -> rsp_data=0x1234, rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stay stable, no ready asserted. Release -> handshake, IDLE next cycle.
- Reset mid-op: rst_n=0 during EXEC -> next cycle rsp_valid=0 and state IDLE. After release, both valid -> requester 0 granted first.

Source files
------------

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 16-bit Shifter between two requesters.
// Optional per-requester saturating grant counters are enabled by defining SHIFT_ARB_CNT_EN.
module shifter_arbiter #(
    parameter int DW    = 16,
    parameter int SW    = 4,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_in,
    input  logic [SW-1:0] req0_val,
    input  logic [1:0]    req0_mode,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_in,
    input  logic [SW-1:0] req1_val,
    input  logic [1:0]    req1_mode,
    output logic [DW-1:0] sh_in,
    output logic [SW-1:0] sh_val,
    output logic [1:0]    sh_mode,
    input  logic [DW-1:0] sh_out,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err
`ifdef SHIFT_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    if (DW != 16 || SW != 4 || CNT_W < 1) begin : g_bad_cfg
        $error("shifter_arbiter: only DW=16, SW=4, CNT_W>=1 are supported");
    end

    state_t        state_q, state_d;
    logic          last_grant;
    logic          grant0, grant1, accept;

    logic [DW-1:0] op_in_p0;
    logic [SW-1:0] op_val_p0;
    logic [1:0]    op_mode_p0;
    logic          op_id_p0;

    logic [DW-1:0] rsp_data_p1;
    logic          rsp_id_p1;
    logic          rsp_err_p1;

    // Illegal mode bypasses the Shifter and echoes the operand back.
    function automatic logic [DW-1:0] sel_result(input logic [1:0]    mode,
                                                 input logic [DW-1:0] operand,
                                                 input logic [DW-1:0] shifted);
        return (mode == MODE_ILLEGAL) ? operand : shifted;
    endfunction

    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        case (state_q)
            IDLE: begin
                grant0 = req0_valid & (~req1_valid | last_grant);
                grant1 = req1_valid & (~req0_valid | ~last_grant);
                if (grant0 | grant1) state_d = EXEC;
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept     = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) last_grant <= grant1;
        end
    end

    // Stage p0: operand register, drives the Shifter from accept until the next accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_in_p0   <= '0;
            op_val_p0  <= '0;
            op_mode_p0 <= '0;
            op_id_p0   <= 1'b0;
        end else if (accept) begin
            op_in_p0   <= grant1 ? req1_in   : req0_in;
            op_val_p0  <= grant1 ? req1_val  : req0_val;
            op_mode_p0 <= grant1 ? req1_mode : req0_mode;
            op_id_p0   <= grant1;
        end
    end

    assign sh_in   = op_in_p0;
    assign sh_val  = op_val_p0;
    assign sh_mode = op_mode_p0;

    // Stage p1: response register, captured at the end of the single EXEC cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data_p1 <= '0;
            rsp_id_p1   <= 1'b0;
            rsp_err_p1  <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_data_p1 <= sel_result(op_mode_p0, op_in_p0, sh_out);
            rsp_id_p1   <= op_id_p0;
            rsp_err_p1  <= (op_mode_p0 == MODE_ILLEGAL);
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_p1;
    assign rsp_id    = rsp_id_p1;
    assign rsp_err   = rsp_err_p1;

`ifdef SHIFT_ARB_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (grant0) grant_cnt0 <= sat_inc(grant_cnt0);
            if (grant1) grant_cnt1 <= sat_inc(grant_cnt1);
        end
    end
`endif

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed self-checking bench for shifter_arbiter, with a behavioural model of the shared Shifter.
// Define SHIFT_ARB_CNT_EN to also check the grant counters.
module tb_shifter_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_in, req1_in;
    logic [3:0]  req0_val, req1_val;
    logic [1:0]  req0_mode, req1_mode;
    logic [15:0] sh_in, sh_out, rsp_data;
    logic [3:0]  sh_val;
    logic [1:0]  sh_mode;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
`ifdef SHIFT_ARB_CNT_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Shifter model; mode 11 returns inverted data so an unbypassed result is visible.
    always_comb begin
        case (sh_mode)
            2'b00:   sh_out = sh_in << sh_val;
            2'b01:   sh_out = $signed(sh_in) >>> sh_val;
            2'b10:   sh_out = (sh_in >> sh_val) | (sh_in << (5'd16 - {1'b0, sh_val}));
            default: sh_out = ~sh_in;
        endcase
    end

    shifter_arbiter #(.DW(16), .SW(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
        .req0_val(req0_val), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
        .req1_val(req1_val), .req1_mode(req1_mode),
        .sh_in(sh_in), .sh_val(sh_val), .sh_mode(sh_mode), .sh_out(sh_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
`ifdef SHIFT_ARB_CNT_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until accepted (bounded); returns one cycle after the accept edge.
    task automatic issue(input logic id, input logic [15:0] din, input logic [3:0] amt,
                         input logic [1:0] md, output logic ok);
        ok = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_in = din; req1_val = amt; req1_mode = md;
        end else begin
            req0_valid = 1'b1; req0_in = din; req0_val = amt; req0_mode = md;
        end
        for (int n = 0; n < 10 && !ok; n++) begin
            #1;
            ok = id ? req1_ready : req0_ready;
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid; lat counts cycles from the accept cycle.
    task automatic collect(output int lat, output logic [15:0] d, output logic id, output logic err);
        lat = 1;
        #1;
        while (!rsp_valid && lat < 10) begin
            tick();
            #1;
            lat++;
        end
        d = rsp_data; id = rsp_id; err = rsp_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
        vectors++; if (rsp_data !== 16'h0000) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        vectors++; if ({sh_in, sh_val, sh_mode} !== 22'h0) begin miscompares++; $display("FAIL reset_sh: got %h/%h/%h want 0/0/0", sh_in, sh_val, sh_mode); end
`ifdef SHIFT_ARB_CNT_EN
        vectors++; if ({grant_cnt0, grant_cnt1} !== 32'h0) begin miscompares++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", grant_cnt0, grant_cnt1); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sll();
        logic ok, id, err; logic [15:0] d; int lat;
        rsp_ready = 1'b1;
        issue(1'b0, 16'h0001, 4'd4, 2'b00, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL sll_accept: got %b want 1", ok); end
        vectors++; if ({sh_in, sh_val, sh_mode} !== {16'h0001, 4'd4, 2'b00}) begin miscompares++; $display("FAIL sll_sh_drive: got %h/%h/%h want 0001/4/0", sh_in, sh_val, sh_mode); end
        collect(lat, d, id, err);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL sll_latency: got %0d want 2", lat); end
        vectors++; if (d !== 16'h0010) begin miscompares++; $display("FAIL sll_data: got %h want 0010", d); end
        vectors++; if ({id, err} !== 2'b00) begin miscompares++; $display("FAIL sll_id_err: got %b%b want 00", id, err); end
        tick(); #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL sll_rsp_drop: got %b want 0", rsp_valid); end
    endtask

    task automatic test_req1_sra_ror();
        logic ok, id, err; logic [15:0] d; int lat;
        rsp_ready = 1'b1;
        issue(1'b1, 16'h8000, 4'd15, 2'b01, ok);
        collect(lat, d, id, err);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL sra_accept: got %b want 1", ok); end
        vectors++; if (d !== 16'hFFFF) begin miscompares++; $display("FAIL sra_data: got %h want FFFF", d); end
        vectors++; if ({id, err} !== 2'b10) begin miscompares++; $display("FAIL sra_id_err: got %b%b want 10", id, err); end
        tick();
        issue(1'b1, 16'h0001, 4'd1, 2'b10, ok);
        collect(lat, d, id, err);
        vectors++; if (d !== 16'h8000) begin miscompares++; $display("FAIL ror_data: got %h want 8000", d); end
        vectors++; if ({id, err, lat[3:0]} !== 6'b10_0010) begin miscompares++; $display("FAIL ror_id_err_lat: got %b%b/%0d want 10/2", id, err, lat); end
        tick();
    endtask

    task automatic test_illegal_mode();
        logic ok, id, err; logic [15:0] d; int lat;
        rsp_ready = 1'b1;
        issue(1'b0, 16'h1234, 4'd5, 2'b11, ok);
        collect(lat, d, id, err);
        vectors++; if (d !== 16'h1234) begin miscompares++; $display("FAIL illegal_data: got %h want 1234", d); end
        vectors++; if ({id, err} !== 2'b01) begin miscompares++; $display("FAIL illegal_id_err: got %b%b want 01", id, err); end
        tick();
    endtask

    task automatic test_round_robin();
        int acc = 0, rsp = 0, both = 0;
        int acc_cyc[4];
        logic acc_id[4], rsp_ids[4];
        logic [15:0] rsp_d[4];
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_in = 16'h0003; req0_val = 4'd2; req0_mode = 2'b00;
        req1_valid = 1'b1; req1_in = 16'hF000; req1_val = 4'd4; req1_mode = 2'b01;
        for (int c = 0; c < 40 && rsp < 4; c++) begin
            #1;
            if (req0_ready && req1_ready) both++;
            if (req0_ready || req1_ready) begin
                if (acc < 4) begin acc_id[acc] = req1_ready; acc_cyc[acc] = c; end
                acc++;
            end
            if (rsp_valid) begin
                if (rsp < 4) begin rsp_d[rsp] = rsp_data; rsp_ids[rsp] = rsp_id; end
                rsp++;
            end
            tick();
            if (acc >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        vectors++; if (rsp !== 4) begin miscompares++; $display("FAIL rr_responses: got %0d want 4", rsp); end
        vectors++; if (both !== 0) begin miscompares++; $display("FAIL rr_dual_ready: got %0d cycles want 0", both); end
        if (rsp == 4) begin
            for (int i = 0; i < 4; i++) begin
                vectors++; if (acc_id[i] !== i[0]) begin miscompares++; $display("FAIL rr_grant%0d: got %b want %b", i, acc_id[i], i[0]); end
                vectors++; if ({rsp_ids[i], rsp_d[i]} !== {i[0], (i[0] ? 16'hFF00 : 16'h000C)}) begin miscompares++; $display("FAIL rr_rsp%0d: got id %b data %h", i, rsp_ids[i], rsp_d[i]); end
                if (i > 0) begin
                    vectors++; if (acc_cyc[i] - acc_cyc[i-1] !== 3) begin miscompares++; $display("FAIL rr_spacing%0d: got %0d want 3", i, acc_cyc[i] - acc_cyc[i-1]); end
                end
            end
        end
`ifdef SHIFT_ARB_CNT_EN
        vectors++; if ({grant_cnt0, grant_cnt1} !== {16'd2, 16'd2}) begin miscompares++; $display("FAIL rr_counters: got %0d/%0d want 2/2", grant_cnt0, grant_cnt1); end
`endif
    endtask

    task automatic test_backpressure();
        logic ok, id, err; logic [15:0] d; int lat;
        rsp_ready = 1'b0;
        issue(1'b1, 16'h00F0, 4'd4, 2'b10, ok);
        collect(lat, d, id, err);
        vectors++; if ({rsp_valid, d} !== {1'b1, 16'h000F}) begin miscompares++; $display("FAIL bp_first: got valid %b data %h want 1/000F", rsp_valid, d); end
        req0_valid = 1'b1; req0_in = 16'hAAAA; req0_val = 4'd1; req0_mode = 2'b00;
        for (int n = 0; n < 5; n++) begin
            tick(); #1;
            vectors++; if ({rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready} !== {1'b1, 1'b1, 16'h000F, 1'b0, 1'b0}) begin
                miscompares++; $display("FAIL bp_hold%0d: got valid %b id %b data %h rdy %b%b", n, rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready);
            end
        end
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        tick(); #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
        req0_valid = 1'b1; #1;
        vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL bp_idle_ready: got %b want 1", req0_ready); end
        req0_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_op();
        logic ok;
        rsp_ready = 1'b1;
        issue(1'b0, 16'h0001, 4'd1, 2'b00, ok);
        rst_n = 1'b0;
        tick(); #1;
        vectors++; if ({rsp_valid, rsp_data, sh_in} !== 33'h0) begin miscompares++; $display("FAIL rst_mid: got valid %b data %h sh_in %h want 0", rsp_valid, rsp_data, sh_in); end
        rst_n = 1'b1;
        tick(); #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_no_rsp: got %b want 0", rsp_valid); end
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL rst_first_grant: got %b%b want 10", req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_in = '0; req0_val = '0; req0_mode = '0;
        req1_valid = 1'b0; req1_in = '0; req1_val = '0; req1_mode = '0;
        test_reset();
        test_sll();
        test_req1_sra_ror();
        test_illegal_mode();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
